// File: rtl/wb_port_arbiter.sv
// Two-requester round-robin arbiter for the register-file write port.
// Applies pipeline hold and zero-register write suppression; write stage is registered.
module wb_port_arbiter #(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned ZERO_REG = 31
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hold,

   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,

   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,

   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [1:0]        grant,
   output logic              prio
);

   localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

   logic              prio_q, prio_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [1:0]        grant_q, grant_d;

   logic              xfer0, xfer1;

   // Ready depends only on valids, hold, reset and the priority pointer.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (!reset && !hold) begin
         if (req0_valid && req1_valid) begin
            req0_ready = ~prio_q;
            req1_ready = prio_q;
         end else begin
            req0_ready = req0_valid;
            req1_ready = req1_valid;
         end
      end
   end

   assign xfer0 = req0_valid && req0_ready;
   assign xfer1 = req1_valid && req1_ready;

   always_comb begin
      prio_d    = prio_q;
      wr_en_d   = 1'b0;
      grant_d   = 2'b00;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (xfer0) begin
         prio_d    = 1'b1;
         grant_d   = 2'b01;
         wr_addr_d = req0_addr;
         wr_data_d = req0_data;
         wr_en_d   = (req0_addr != ZeroAddr);
      end else if (xfer1) begin
         prio_d    = 1'b0;
         grant_d   = 2'b10;
         wr_addr_d = req1_addr;
         wr_data_d = req1_data;
         wr_en_d   = (req1_addr != ZeroAddr);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prio_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         grant_q   <= 2'b00;
      end else begin
         prio_q    <= prio_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         grant_q   <= grant_d;
      end
   end

   assign prio    = prio_q;
   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign grant   = grant_q;

   a_ready_excl : assert property (@(posedge clk) disable iff (reset)
      !(req0_ready && req1_ready));
   a_grant_onehot : assert property (@(posedge clk) disable iff (reset)
      $onehot0(grant_q));
   a_en_implies_grant : assert property (@(posedge clk) disable iff (reset)
      wr_en_q |-> (grant_q != 2'b00));

endmodule
